// File: rtl/spare_sram_ctrl.sv
// Spare SRAM controller: block-remap table filled by BISR and access sequencer
// for the one-hot-selected spare bank array.
module spare_sram_ctrl #(
    parameter int NUM_SPARE = 25,
    parameter int ADDR_W    = 15,
    parameter int BLK_W     = ADDR_W - 7,
    parameter int CNT_W     = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REPAIR_VALID,
    input  logic [BLK_W-1:0]     REPAIR_BLK,
    output logic                 REPAIR_READY,
    output logic                 REPAIR_DONE,
    output logic [1:0]           REPAIR_STATUS,
    output logic                 FULL,
    output logic [CNT_W-1:0]     USED_CNT,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_WRITE,
    input  logic [ADDR_W-1:0]    REQ_ADDR,
    input  logic [7:0]           REQ_WDATA,
    output logic                 RSP_VALID,
    output logic                 RSP_HIT,
    output logic [7:0]           RSP_RDATA,
    output logic [6:0]           MEM_ADDR,
    output logic                 MEM_CE,
    output logic                 MEM_WEB,
    output logic [NUM_SPARE-1:0] MEM_OEB,
    output logic [NUM_SPARE-1:0] MEM_CSB,
    output logic [7:0]           MEM_IDATA,
    input  logic [7:0]           SPARE_ODATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SETUP,
        S_STROBE,
        S_READ,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic [NUM_SPARE-1:0]   valid_q;
    logic [BLK_W-1:0]       tag_q [NUM_SPARE];
    logic [CNT_W-1:0]       used_cnt_q;
    logic                   full_q;
    logic                   repair_done_q;
    logic [1:0]             repair_status_q;
    logic                   rsp_valid_q;
    logic                   rsp_hit_q;
    logic [7:0]             rsp_rdata_q;
    logic [6:0]             mem_addr_q;
    logic                   mem_ce_q;
    logic                   mem_web_q;
    logic [NUM_SPARE-1:0]   mem_oeb_q;
    logic [NUM_SPARE-1:0]   mem_csb_q;
    logic [7:0]             mem_idata_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             wdata_q;
    logic                   write_q;
    logic [CNT_W-1:0]       idx_q;

    logic                   lk_hit;
    logic [CNT_W-1:0]       lk_idx;
    logic                   rp_match;
    logic [BLK_W-1:0]       req_blk;

    assign req_blk = addr_q[ADDR_W-1:7];

    // Table search for the latched request (lowest index wins) and for a repair duplicate.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        rp_match = 1'b0;
        for (int i = NUM_SPARE - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_blk)) begin
                lk_hit = 1'b1;
                lk_idx = CNT_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == REPAIR_BLK)) begin
                rp_match = 1'b1;
            end
        end
    end

    // Handshakes are combinational; repair wins over an access in IDLE.
    assign REPAIR_READY = (state_q == S_IDLE);
    assign REQ_READY    = (state_q == S_IDLE) && !REPAIR_VALID;

    // Repair table maintenance and access strobe sequencing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= S_IDLE;
            valid_q         <= '0;
            for (int i = 0; i < NUM_SPARE; i++) tag_q[i] <= '0;
            used_cnt_q      <= '0;
            full_q          <= 1'b0;
            repair_done_q   <= 1'b0;
            repair_status_q <= 2'b00;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            mem_addr_q      <= '0;
            mem_ce_q        <= 1'b0;
            mem_web_q       <= 1'b1;
            mem_oeb_q       <= '1;
            mem_csb_q       <= '1;
            mem_idata_q     <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            write_q         <= 1'b0;
            idx_q           <= '0;
        end else begin
            repair_done_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (REPAIR_VALID) begin
                        repair_done_q <= 1'b1;
                        if (rp_match) begin
                            repair_status_q <= 2'b01;
                        end else if (used_cnt_q == CNT_W'(NUM_SPARE)) begin
                            repair_status_q <= 2'b10;
                        end else begin
                            tag_q[used_cnt_q]   <= REPAIR_BLK;
                            valid_q[used_cnt_q] <= 1'b1;
                            used_cnt_q          <= used_cnt_q + CNT_W'(1);
                            full_q              <= (used_cnt_q == CNT_W'(NUM_SPARE - 1));
                            repair_status_q     <= 2'b00;
                        end
                    end else if (REQ_VALID) begin
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WDATA;
                        write_q <= REQ_WRITE;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    idx_q <= lk_idx;
                    if (lk_hit) begin
                        mem_addr_q  <= addr_q[6:0];
                        mem_csb_q   <= ~(NUM_SPARE'(1) << lk_idx);
                        mem_web_q   <= ~write_q;
                        mem_idata_q <= wdata_q;
                        mem_ce_q    <= 1'b0;
                        state_q     <= S_SETUP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end
                end
                S_SETUP: begin
                    mem_ce_q <= 1'b1;
                    state_q  <= S_STROBE;
                end
                S_STROBE: begin
                    mem_ce_q <= 1'b0;
                    if (write_q) begin
                        mem_csb_q   <= '1;
                        mem_web_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        mem_oeb_q <= ~(NUM_SPARE'(1) << idx_q);
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    rsp_rdata_q <= SPARE_ODATA;
                    rsp_valid_q <= 1'b1;
                    rsp_hit_q   <= 1'b1;
                    mem_csb_q   <= '1;
                    mem_oeb_q   <= '1;
                    mem_web_q   <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    rsp_hit_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign REPAIR_DONE   = repair_done_q;
    assign REPAIR_STATUS = repair_status_q;
    assign FULL          = full_q;
    assign USED_CNT      = used_cnt_q;
    assign RSP_VALID     = rsp_valid_q;
    assign RSP_HIT       = rsp_hit_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_CE        = mem_ce_q;
    assign MEM_WEB       = mem_web_q;
    assign MEM_OEB       = mem_oeb_q;
    assign MEM_CSB       = mem_csb_q;
    assign MEM_IDATA     = mem_idata_q;

endmodule
